block_reader: RTL
=================

BLOCK_READER -- requirements
Module: block_reader

Interface
REQ-001 Parameter BLOCK_COUNT, default 4, number of RAM blocks in the bank being read.
REQ-002 Parameter BLOCK_WIDTH, default 32, RAM read-port word width in bits.
REQ-003 Parameter BLOCK_DEPTH, default 480, words per RAM block.
REQ-004 Parameter PANEL_WIDTH, default 8, panel width in pixels.
REQ-005 Parameter PANEL_HEIGHT, default 16, panel height in pixels.
REQ-006 Parameter COLOR_COUNT, default 3, bytes per pixel.
REQ-007 Port I_clk, input, 1, the single clock for the block.
REQ-008 Port I_rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port I_start, input, 1, single-cycle request to read one panel.
REQ-010 Port I_block, input, clog2(BLOCK_COUNT), block to read, sampled with I_start.
REQ-011 Port I_slot, input, clog2(PANELS_PER_BLOCK), panel slot within the block, sampled with I_start.
REQ-012 Port I_abort, input, 1, synchronous cancel of the current read.
REQ-013 Port O_ceb, output, BLOCK_COUNT, one-hot read enable, one bit per RAM port B.
REQ-014 Port O_adb, output, clog2(BLOCK_DEPTH), shared read address for all RAM port B inputs.
REQ-015 Port I_dout, input, BLOCK_COUNT*BLOCK_WIDTH, flattened RAM read data; block b occupies bits [b*BLOCK_WIDTH +: BLOCK_WIDTH].
REQ-016 Port O_data, output, 8, output byte stream.
REQ-017 Port O_valid, output, 1, O_data is valid.
REQ-018 Port I_ready, input, 1, downstream accepts the byte.
REQ-019 Port O_busy, output, 1, a panel read is in progress.
REQ-020 Port O_done, output, 1, one-cycle pulse when the last byte of a panel has been accepted.
REQ-021 Port O_error, output, 1, one-cycle pulse when a start request is rejected.

Function
REQ-022 Derived constants: WORDS_PER_PANEL = PANEL_WIDTH*PANEL_HEIGHT*COLOR_COUNT*8/BLOCK_WIDTH (96 at defaults); PANELS_PER_BLOCK = BLOCK_DEPTH/WORDS_PER_PANEL (5 at defaults).
REQ-023 The state machine has three states: IDLE, READ and DRAIN.
REQ-024 IDLE to READ on I_start with I_slot < PANELS_PER_BLOCK and I_block < BLOCK_COUNT; the block then latches base = I_slot*WORDS_PER_PANEL and the block select.
REQ-025 I_start with an out-of-range slot or block leaves the state at IDLE and pulses O_error on the next cycle.
REQ-026 I_start while O_busy=1 is ignored, with no error pulse.
REQ-027 RAM read latency is fixed at 1 cycle: data for a read issued at cycle n is captured from the selected I_dout slice at cycle n+1.
REQ-028 A read is issued (O_ceb one-hot asserted, O_adb = base + word count) only when in-flight reads plus occupied FIFO entries < 2.
REQ-029 READ moves to DRAIN once word WORDS_PER_PANEL-1 has been issued.
REQ-030 DRAIN moves to IDLE when the FIFO is empty, no read is in flight and the final byte handshake completes; O_done pulses in that same cycle.
REQ-031 Each word is emitted as BLOCK_WIDTH/8 bytes, MSB byte first; a byte counter advances only on O_valid && I_ready.
REQ-032 O_valid=1 and no handshake: O_data is held stable; O_valid never drops without a handshake, except on abort or reset.
REQ-033 With I_ready held at 1, the block sustains 1 byte per cycle; first O_valid appears no later than 3 cycles after I_start.
REQ-034 I_abort in any state: next cycle returns to IDLE, flushes the FIFO, discards the in-flight read, deasserts O_valid and O_busy, and gives no O_done; I_abort takes priority over a simultaneous I_start.
REQ-035 O_ceb = 0 whenever the state is IDLE.

Reset
REQ-036 I_rst_n low asynchronously forces: state IDLE, O_ceb=0, O_adb=0, O_data=0, O_valid=0, O_busy=0, O_done=0, O_error=0, all counters and FIFO pointers at 0.
REQ-037 Reset asserted mid-panel discards all progress; the first cycle after deassertion behaves as IDLE.

Structure
REQ-038 The derived constants and the state enum live in the shared package buffer_pkg, which the writer side also uses.
REQ-039 The 2-entry word FIFO is a separate sub-module, word_skid_fifo.

Verification
REQ-040 Preload block 2 slot 1 with word k = 0xA0000000+k; start with I_block=2, I_slot=1, I_ready=1 -> addresses 96..191 issued, only O_ceb=4'b0100 ever asserted, 384 bytes starting A0,00,00,00 and ending A0,00,00,5F, O_done after the last byte.
REQ-041 Same read with I_ready toggling randomly at 50% -> identical byte sequence, no drops or duplicates, O_data stable while stalled.
REQ-042 I_start with I_slot=5 -> O_error pulses once, O_busy stays 0, O_ceb stays 0.
REQ-043 Assert I_abort after byte 100 -> O_valid=0 and O_busy=0 the next cycle, no O_done; a following start on block 0 slot 0 streams from address 0 correctly.
REQ-044 Assert I_rst_n low during DRAIN -> all outputs 0 immediately; after release, a new start completes normally.
REQ-045 I_start pulsed while O_busy=1 -> ignored, with no extra reads and no O_error.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared definitions for the panel buffer (reader and writer sides).
// Holds the default geometry, the derived-constant helpers and the reader
// FSM state type so both sides agree on panel layout inside a RAM block.
package buffer_pkg;

  // Default bank / panel geometry.
  localparam int DEF_BLOCK_COUNT  = 4;
  localparam int DEF_BLOCK_WIDTH  = 32;
  localparam int DEF_BLOCK_DEPTH  = 480;
  localparam int DEF_PANEL_WIDTH  = 8;
  localparam int DEF_PANEL_HEIGHT = 16;
  localparam int DEF_COLOR_COUNT  = 3;

  // RAM words needed to hold one panel.
  function automatic int calc_words_per_panel(input int pw, input int ph,
                                               input int cc, input int bw);
    return (pw * ph * cc * 8) / bw;
  endfunction

  // Whole panels that fit in one RAM block.
  function automatic int calc_panels_per_block(input int depth, input int wpp);
    return depth / wpp;
  endfunction

  // $clog2 that never returns a zero-width field.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WORDS_PER_PANEL  = calc_words_per_panel(DEF_PANEL_WIDTH,
                                          DEF_PANEL_HEIGHT, DEF_COLOR_COUNT, DEF_BLOCK_WIDTH);
  localparam int DEF_PANELS_PER_BLOCK = calc_panels_per_block(DEF_BLOCK_DEPTH,
                                          DEF_WORDS_PER_PANEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/block_reader_if.sv
// Bus bundle between a panel requester / byte sink / RAM bank and
// block_reader.
//   Request : I_start, I_block, I_slot, I_abort
//   RAM     : O_ceb (one-hot enable), O_adb (shared address), I_dout (flat data)
//   Stream  : O_data, O_valid, I_ready
//   Status  : O_busy, O_done, O_error
// Stream handshake: a byte transfers on every clock edge where O_valid and
// I_ready are both high; once O_valid is high, O_data is held and O_valid
// stays high until that transfer happens (abort and reset excepted).
// Modport slave is the reader's view, master is the environment's view.
interface block_reader_if
  import buffer_pkg::*;
#(
  parameter int BLOCK_COUNT = DEF_BLOCK_COUNT,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int ADDR_W      = clog2_min1(DEF_BLOCK_DEPTH),
  parameter int BLK_W       = clog2_min1(DEF_BLOCK_COUNT),
  parameter int SLOT_W      = clog2_min1(DEF_PANELS_PER_BLOCK)
);
  logic                               I_start;
  logic [BLK_W-1:0]                   I_block;
  logic [SLOT_W-1:0]                  I_slot;
  logic                               I_abort;
  logic [BLOCK_COUNT-1:0]             O_ceb;
  logic [ADDR_W-1:0]                  O_adb;
  logic [BLOCK_COUNT*BLOCK_WIDTH-1:0] I_dout;
  logic [7:0]                         O_data;
  logic                               O_valid;
  logic                               I_ready;
  logic                               O_busy;
  logic                               O_done;
  logic                               O_error;

  modport slave (
    input  I_start, I_block, I_slot, I_abort, I_dout, I_ready,
    output O_ceb, O_adb, O_data, O_valid, O_busy, O_done, O_error
  );

  modport master (
    output I_start, I_block, I_slot, I_abort, I_dout, I_ready,
    input  O_ceb, O_adb, O_data, O_valid, O_busy, O_done, O_error
  );
endinterface

// File: rtl/word_skid_fifo.sv
// Two-entry word FIFO between the RAM read port and the byte serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous empty (pointers and count to 0)
//   push, din  : write one word (ignored when full unless popping too)
//   pop        : drop the head word (ignored when empty)
//   dout       : head word, count : occupied entries (0..2)
module word_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  // When full, a simultaneous pop frees the slot the write pointer aims at.
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/block_reader.sv
// Reads one panel out of a bank of RAM blocks and streams it as bytes.
//   I_clk, I_rst_n : clock, asynchronous active-low reset
//   bus            : block_reader_if.slave (request, RAM port B, byte stream,
//                    status pulses)
//   O_state        : current FSM state, for observation
// A request picks a block and a panel slot; the panel occupies
// WORDS_PER_PANEL consecutive words starting at slot*WORDS_PER_PANEL.
// Words come back one cycle after the read and are queued in a 2-entry
// FIFO; each word leaves as BLOCK_WIDTH/8 bytes, most significant first.
module block_reader
  import buffer_pkg::*;
#(
  parameter int BLOCK_COUNT  = DEF_BLOCK_COUNT,
  parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int BLOCK_DEPTH  = DEF_BLOCK_DEPTH,
  parameter int PANEL_WIDTH  = DEF_PANEL_WIDTH,
  parameter int PANEL_HEIGHT = DEF_PANEL_HEIGHT,
  parameter int COLOR_COUNT  = DEF_COLOR_COUNT
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  block_reader_if.slave  bus,
  output reader_state_t  O_state
);
  localparam int WPP    = calc_words_per_panel(PANEL_WIDTH, PANEL_HEIGHT,
                                               COLOR_COUNT, BLOCK_WIDTH);
  localparam int PPB    = calc_panels_per_block(BLOCK_DEPTH, WPP);
  localparam int BPW    = BLOCK_WIDTH / 8;
  localparam int ADDR_W = clog2_min1(BLOCK_DEPTH);
  localparam int BLK_W  = clog2_min1(BLOCK_COUNT);
  localparam int SLOT_W = clog2_min1(PPB);
  localparam int CNT_W  = clog2_min1(WPP + 1);
  localparam int BYTE_W = clog2_min1(BPW);

  // Range limits one bit wider than the request fields so the compare
  // works even when the field can hold exactly the limit value.
  localparam logic [SLOT_W:0]   PPB_L = (SLOT_W + 1)'(PPB);
  localparam logic [BLK_W:0]    BLK_L = (BLK_W + 1)'(BLOCK_COUNT);
  localparam logic [ADDR_W-1:0] WPP_A = ADDR_W'(WPP);

  reader_state_t    state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [BLK_W-1:0]  blk_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [BYTE_W-1:0] byte_cnt_q;
  logic              in_flight_q;
  logic              error_q;

  logic [BLOCK_WIDTH-1:0] fifo_dout;
  logic [BLOCK_WIDTH-1:0] rd_word;
  logic [BLOCK_WIDTH-1:0] shifted;
  logic [1:0]             fifo_count;
  logic [2:0]             occ;
  logic [BYTE_W-1:0]      byte_idx;
  logic                   req_ok;
  logic                   accept_start;
  logic                   fifo_valid;
  logic                   last_byte;
  logic                   xfer;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   done;

  assign req_ok       = ({1'b0, bus.I_slot} < PPB_L) && ({1'b0, bus.I_block} < BLK_L);
  assign accept_start = (state_q == ST_IDLE) && bus.I_start && !bus.I_abort && req_ok;

  // Reads in flight count against FIFO space so a returning word always
  // has a slot to land in.
  assign occ        = {2'b00, in_flight_q} + {1'b0, fifo_count};
  assign fifo_valid = (fifo_count != 2'd0);
  assign last_byte  = (byte_cnt_q == BYTE_W'(BPW - 1));
  assign xfer       = fifo_valid && bus.I_ready;
  assign pop        = xfer && last_byte;
  assign push       = in_flight_q && !bus.I_abort;
  assign rd_word    = bus.I_dout[blk_q * BLOCK_WIDTH +: BLOCK_WIDTH];

  // Byte 0 of a word is its most significant byte.
  assign byte_idx = BYTE_W'(BPW - 1) - byte_cnt_q;
  assign shifted  = fifo_dout >> {byte_idx, 3'b000};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_start) state_d = ST_READ;
      end
      ST_READ: begin
        issue = (occ < 3'd2);
        if (issue && (word_cnt_q == CNT_W'(WPP - 1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Every word is issued; finish on the handshake of the final byte.
        if (pop && (fifo_count == 2'd1) && !in_flight_q) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.I_abort) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      blk_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      in_flight_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      error_q     <= (state_q == ST_IDLE) && bus.I_start && !bus.I_abort && !req_ok;
      if (bus.I_abort || done) begin
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
      end else begin
        if (accept_start) begin
          base_q     <= ADDR_W'(bus.I_slot) * WPP_A;
          blk_q      <= bus.I_block;
          word_cnt_q <= '0;
          byte_cnt_q <= '0;
        end
        if (issue) word_cnt_q <= word_cnt_q + 1'b1;
        if (xfer)  byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
      end
    end
  end

  word_skid_fifo #(.WIDTH(BLOCK_WIDTH)) u_fifo (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .flush (bus.I_abort),
    .push  (push),
    .din   (rd_word),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bus.O_ceb   = issue ? (BLOCK_COUNT'(1) << blk_q) : '0;
  assign bus.O_adb   = base_q + ADDR_W'(word_cnt_q);
  assign bus.O_valid = fifo_valid;
  assign bus.O_data  = fifo_valid ? shifted[7:0] : 8'h00;
  assign bus.O_busy  = (state_q != ST_IDLE);
  assign bus.O_done  = done;
  assign bus.O_error = error_q;
  assign O_state     = state_q;

endmodule
